// File: rtl/i2c_slave_regfile.sv
// I2C target with a pointer register and four 16-bit registers.
// Scl/Sda are oversampled on Clk; reg 0 mirrors Sensor_data (read-only), regs 1..3 are read/write.
module i2c_slave_regfile #(
  parameter logic [6:0]  SLAVE_ADR   = 7'b1001000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] THYST_RST   = 16'h4B00,
  parameter logic [15:0] TOS_RST     = 16'h5000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Scl,
  inout  wire         Sda,
  input  logic [15:0] Sensor_data,
  output logic [15:0] Reg_cfg,
  output logic [15:0] Reg_thyst,
  output logic [15:0] Reg_tos,
  output logic [1:0]  Pointer_out,
  output logic        Wr_strobe,
  output logic        Busy
);

  typedef enum logic [3:0] {
    IDLE, ADR, ACK_ADR, PTR, ACK_PTR, WR_MSB, ACK_MSB, WR_LSB, ACK_LSB,
    RD_MSB, MACK_MSB, RD_LSB, MACK_LSB, WAIT_STOP
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d, fall_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_ev, stop_ev;
  logic [2:0]             bit_cnt, bit_cnt_n;
  logic [7:0]             shift, shift_n, data_hi, data_hi_n;
  logic [7:0]             byte_in;
  logic                   rw, rw_n;
  logic                   ack_phase, ack_phase_n;
  logic [1:0]             pointer, pointer_n;
  logic [15:0]            reg_cfg, reg_cfg_n, reg_thyst, reg_thyst_n, reg_tos, reg_tos_n;
  logic [15:0]            rd_word, rd_word_n, rd_sel;
  logic                   sda_low, sda_low_n;
  logic                   busy, busy_n;
  logic                   wr_strobe_n;

  assign Sda = sda_low ? 1'b0 : 1'bz;

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_in  = {shift[6:0], sda_s};

  assign Reg_cfg     = reg_cfg;
  assign Reg_thyst   = reg_thyst;
  assign Reg_tos     = reg_tos;
  assign Pointer_out = pointer;
  assign Busy        = busy;

  always_comb begin
    rd_sel = Sensor_data;
    case (pointer)
      2'd1:    rd_sel = reg_cfg;
      2'd2:    rd_sel = reg_thyst;
      2'd3:    rd_sel = reg_tos;
      default: rd_sel = Sensor_data;
    endcase
  end

  // Synchronisers idle high so reset release never looks like a bus event.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      fall_d   <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], Scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], Sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
      fall_d   <= scl_fall;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      data_hi   <= '0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      pointer   <= '0;
      reg_cfg   <= '0;
      reg_thyst <= THYST_RST;
      reg_tos   <= TOS_RST;
      rd_word   <= '0;
      sda_low   <= 1'b0;
      busy      <= 1'b0;
      Wr_strobe <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      data_hi   <= data_hi_n;
      rw        <= rw_n;
      ack_phase <= ack_phase_n;
      pointer   <= pointer_n;
      reg_cfg   <= reg_cfg_n;
      reg_thyst <= reg_thyst_n;
      reg_tos   <= reg_tos_n;
      rd_word   <= rd_word_n;
      sda_low   <= sda_low_n;
      busy      <= busy_n;
      Wr_strobe <= wr_strobe_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    data_hi_n   = data_hi;
    rw_n        = rw;
    ack_phase_n = ack_phase;
    pointer_n   = pointer;
    reg_cfg_n   = reg_cfg;
    reg_thyst_n = reg_thyst;
    reg_tos_n   = reg_tos;
    rd_word_n   = rd_word;
    sda_low_n   = sda_low;
    busy_n      = busy;
    wr_strobe_n = 1'b0;

    if (start_ev) begin
      state_n     = ADR;
      bit_cnt_n   = '0;
      ack_phase_n = 1'b0;
      sda_low_n   = 1'b0;
    end else if (stop_ev) begin
      state_n     = IDLE;
      bit_cnt_n   = '0;
      ack_phase_n = 1'b0;
      sda_low_n   = 1'b0;
      busy_n      = 1'b0;
    end else begin
      case (state)
        ADR, PTR, WR_MSB, WR_LSB: begin
          if (scl_rise) begin
            shift_n   = byte_in;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ack_phase_n = 1'b0;
              case (state)
                ADR: begin
                  if (byte_in[7:1] == SLAVE_ADR) begin
                    state_n = ACK_ADR;
                    busy_n  = 1'b1;
                    rw_n    = byte_in[0];
                  end else begin
                    state_n = WAIT_STOP;
                    busy_n  = 1'b0;
                  end
                end
                PTR: begin
                  if (byte_in[7:2] != 6'd0) begin
                    state_n = WAIT_STOP;
                    busy_n  = 1'b0;
                  end else begin
                    pointer_n = byte_in[1:0];
                    state_n   = ACK_PTR;
                  end
                end
                WR_MSB: begin
                  data_hi_n = byte_in;
                  state_n   = ACK_MSB;
                end
                default: state_n = ACK_LSB;
              endcase
            end
          end
        end

        // First falling edge after the byte drives the ACK, the second ends it.
        ACK_ADR, ACK_PTR, ACK_MSB, ACK_LSB: begin
          if (state == ACK_LSB && ack_phase && scl_rise && pointer != 2'd0) begin
            wr_strobe_n = 1'b1;
            case (pointer)
              2'd1:    reg_cfg_n   = {data_hi, shift};
              2'd2:    reg_thyst_n = {data_hi, shift};
              default: reg_tos_n   = {data_hi, shift};
            endcase
          end
          if (fall_d) begin
            if (!ack_phase) begin
              sda_low_n   = 1'b1;
              ack_phase_n = 1'b1;
            end else begin
              ack_phase_n = 1'b0;
              bit_cnt_n   = '0;
              sda_low_n   = 1'b0;
              case (state)
                ACK_ADR: begin
                  if (rw) begin
                    state_n   = RD_MSB;
                    rd_word_n = rd_sel;
                    sda_low_n = ~rd_sel[15];
                  end else begin
                    state_n = PTR;
                  end
                end
                ACK_PTR: state_n = WR_MSB;
                ACK_MSB: state_n = WR_LSB;
                default: state_n = WR_MSB;
              endcase
            end
          end
        end

        RD_MSB, RD_LSB: begin
          if (fall_d)
            sda_low_n = (state == RD_MSB) ? ~rd_word[{1'b1, ~bit_cnt}]
                                          : ~rd_word[{1'b0, ~bit_cnt}];
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ack_phase_n = 1'b0;
              state_n     = (state == RD_MSB) ? MACK_MSB : MACK_LSB;
            end
          end
        end

        MACK_MSB, MACK_LSB: begin
          if (fall_d) begin
            if (!ack_phase) begin
              sda_low_n   = 1'b0;
              ack_phase_n = 1'b1;
            end else begin
              ack_phase_n = 1'b0;
              bit_cnt_n   = '0;
              if (state == MACK_MSB) begin
                state_n   = RD_LSB;
                sda_low_n = ~rd_word[7];
              end else begin
                state_n   = RD_MSB;
                rd_word_n = rd_sel;
                sda_low_n = ~rd_sel[15];
              end
            end
          end else if (scl_rise && ack_phase && sda_s) begin
            state_n     = WAIT_STOP;
            ack_phase_n = 1'b0;
            busy_n      = 1'b0;
          end
        end

        default: sda_low_n = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged bus master plus table-driven writes.
module tb_i2c_slave_regfile;

  localparam time Q = 50;

  logic        clk, rst, scl, m_low;
  logic [15:0] sensor;
  wire         sda_bus;
  logic [15:0] reg_cfg, reg_thyst, reg_tos;
  logic [1:0]  pointer_out;
  logic        wr_strobe, busy;

  int unsigned pass_cnt, total_cnt, strobe_cnt, drive_cnt;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave_regfile #(.SLAVE_ADR(7'b1001000), .SYNC_STAGES(2),
                      .THYST_RST(16'h4B00), .TOS_RST(16'h5000)) dut (
    .Clk(clk), .Rst(rst), .Scl(scl), .Sda(sda_bus), .Sensor_data(sensor),
    .Reg_cfg(reg_cfg), .Reg_thyst(reg_thyst), .Reg_tos(reg_tos),
    .Pointer_out(pointer_out), .Wr_strobe(wr_strobe), .Busy(busy)
  );

  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (!m_low && sda_bus === 1'b0) drive_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    ack = sda_bus; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl = 1'b1; #Q;
      b[i] = sda_bus;
      #Q; scl = 1'b0;
    end
    #Q; m_low = ~nack;
    #Q; scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
    m_low = 1'b0;
  endtask

  task automatic write_txn(input logic [1:0] ptr, input logic [15:0] data, output logic [3:0] acks);
    i2c_start();
    write_byte(8'h90, acks[3]);
    write_byte({6'd0, ptr}, acks[2]);
    write_byte(data[15:8], acks[1]);
    write_byte(data[7:0], acks[0]);
    i2c_stop();
  endtask

  task automatic read_txn(input logic [1:0] ptr, output logic [2:0] acks, output logic [15:0] word);
    logic [7:0] hi, lo;
    i2c_start();
    write_byte(8'h90, acks[2]);
    write_byte({6'd0, ptr}, acks[1]);
    i2c_start();
    write_byte(8'h91, acks[0]);
    read_byte(1'b0, hi);
    read_byte(1'b1, lo);
    i2c_stop();
    word = {hi, lo};
  endtask

  typedef struct {
    logic [1:0]  ptr;
    logic [15:0] data;
    logic [15:0] cfg, thyst, tos;
    int unsigned strobes;
  } vec_t;

  vec_t        vecs[4];
  logic [3:0]  acks4;
  logic [2:0]  acks3;
  logic        ack;
  logic [15:0] word;
  int unsigned s0;

  initial begin
    pass_cnt = 0; total_cnt = 0; strobe_cnt = 0; drive_cnt = 0;
    vecs[0] = '{ptr: 2'd2, data: 16'h1234, cfg: 16'h0000, thyst: 16'h1234, tos: 16'h5000, strobes: 1};
    vecs[1] = '{ptr: 2'd1, data: 16'h00A5, cfg: 16'h00A5, thyst: 16'h1234, tos: 16'h5000, strobes: 1};
    vecs[2] = '{ptr: 2'd3, data: 16'h7FFF, cfg: 16'h00A5, thyst: 16'h1234, tos: 16'h7FFF, strobes: 1};
    vecs[3] = '{ptr: 2'd0, data: 16'hFFFF, cfg: 16'h00A5, thyst: 16'h1234, tos: 16'h7FFF, strobes: 0};

    scl = 1'b1; m_low = 1'b0; sensor = 16'hABCD; rst = 1'b1;
    #(2*Q);
    rst = 1'b0;
    #(2*Q);
    check("rst_cfg", {16'd0, reg_cfg}, 32'h0000);
    check("rst_thyst", {16'd0, reg_thyst}, 32'h4B00);
    check("rst_tos", {16'd0, reg_tos}, 32'h5000);
    check("rst_ptr_busy_strobe", {29'd0, pointer_out, busy}, 32'd0);
    check("rst_sda_released", {31'd0, sda_bus}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      s0 = strobe_cnt;
      write_txn(vecs[i].ptr, vecs[i].data, acks4);
      #Q;
      check($sformatf("wr%0d_acks", i), {28'd0, acks4}, 32'd0);
      check($sformatf("wr%0d_cfg", i), {16'd0, reg_cfg}, {16'd0, vecs[i].cfg});
      check($sformatf("wr%0d_thyst", i), {16'd0, reg_thyst}, {16'd0, vecs[i].thyst});
      check($sformatf("wr%0d_tos", i), {16'd0, reg_tos}, {16'd0, vecs[i].tos});
      check($sformatf("wr%0d_strobes", i), strobe_cnt - s0, vecs[i].strobes);
      check($sformatf("wr%0d_ptr", i), {30'd0, pointer_out}, {30'd0, vecs[i].ptr});
      check($sformatf("wr%0d_busy", i), {31'd0, busy}, 32'd0);
    end

    // Read of register 0: word ABCD, Busy high mid-transaction.
    i2c_start();
    write_byte(8'h90, acks3[2]);
    write_byte(8'h00, acks3[1]);
    i2c_start();
    write_byte(8'h91, acks3[0]);
    check("rd0_busy_mid", {31'd0, busy}, 32'd1);
    read_byte(1'b0, word[15:8]);
    read_byte(1'b1, word[7:0]);
    i2c_stop();
    #Q;
    check("rd0_acks", {29'd0, acks3}, 32'd0);
    check("rd0_word", {16'd0, word}, 32'hABCD);
    check("rd0_busy_after", {31'd0, busy}, 32'd0);

    for (int p = 1; p < 4; p++) begin
      read_txn(p[1:0], acks3, word);
      check($sformatf("rdback%0d_acks", p), {29'd0, acks3}, 32'd0);
      check($sformatf("rdback%0d_word", p), {16'd0, word},
            (p == 1) ? 32'h00A5 : (p == 2) ? 32'h1234 : 32'h7FFF);
    end

    // Wrong address: no ACK, no drive, Busy low.
    drive_cnt = 0;
    i2c_start();
    write_byte(8'h92, ack);
    check("badadr_nack", {31'd0, ack}, 32'd1);
    check("badadr_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h00, ack);
    check("badadr_data_nack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("badadr_no_drive", drive_cnt, 32'd0);
    check("badadr_thyst", {16'd0, reg_thyst}, 32'h1234);

    // Bad pointer: pointer NACKed, following data ignored.
    s0 = strobe_cnt;
    write_txn(2'd1, 16'h1122, acks4);
    acks4 = 4'b0000;
    i2c_start();
    write_byte(8'h90, acks4[3]);
    write_byte(8'h05, acks4[2]);
    write_byte(8'h11, acks4[1]);
    write_byte(8'h22, acks4[0]);
    i2c_stop();
    #Q;
    check("badptr_acks", {28'd0, acks4}, 32'b0111);
    check("badptr_cfg", {16'd0, reg_cfg}, 32'h1122);
    check("badptr_strobes", strobe_cnt - s0, 32'd1);

    // STOP after 4 bits of the LSB byte.
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h01, ack);
    write_byte(8'hAA, ack);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    i2c_stop();
    #Q;
    check("partial_cfg", {16'd0, reg_cfg}, 32'h1122);
    check("partial_strobes", strobe_cnt - s0, 32'd0);
    check("partial_busy", {31'd0, busy}, 32'd0);
    read_txn(2'd1, acks3, word);
    check("partial_recover", {13'd0, acks3, word}, 32'h1122);

    // Reset while the target drives a 0 data bit (Sensor bit 15 = 0).
    sensor = 16'h1234;
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h00, ack);
    i2c_start();
    write_byte(8'h91, ack);
    check("rstmid_driving0", {31'd0, sda_bus}, 32'd0);
    rst = 1'b1;
    #1;
    check("rstmid_released", {31'd0, sda_bus}, 32'd1);
    check("rstmid_regs", {reg_thyst, reg_tos}, 32'h4B00_5000);
    check("rstmid_cfg_ptr", {14'd0, pointer_out, reg_cfg}, 32'd0);
    #(2*Q - 1);
    rst = 1'b0;
    #(2*Q);
    s0 = strobe_cnt;
    write_txn(2'd3, 16'hBEEF, acks4);
    #Q;
    check("post_rst_acks", {28'd0, acks4}, 32'd0);
    check("post_rst_tos", {16'd0, reg_tos}, 32'hBEEF);
    check("post_rst_strobes", strobe_cnt - s0, 32'd1);
    read_txn(2'd3, acks3, word);
    check("post_rst_read", {13'd0, acks3, word}, 32'hBEEF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
